// File: rtl/stereo_pan_mixer_pkg.sv
// Shared audio definitions for the pan mixer: default widths, pan reference codes,
// FSM encoding and the output saturation helper.
package audio_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int PAN_W_DEF    = 4;
  localparam int PAN_LEFT     = 0;
  localparam int PAN_CENTRE   = 2 ** (PAN_W_DEF - 1);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Clamp a signed value into the range of a w-bit two's complement word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/stereo_pan_mixer_if.sv
// Frame-level bus between the voice generators / output stage and the pan mixer.
interface stereo_pan_mixer_if #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16,
  parameter int PAN_W    = 4
) ();

  logic                         sample_valid_in;
  logic [NUM_CH*SAMPLE_W-1:0]   note_data_in;
  logic [NUM_CH*PAN_W-1:0]      pan_in;
  logic [NUM_CH-1:0]            mute_in;
  logic                         stereo_on;
  logic [SAMPLE_W-1:0]          sample_l;
  logic [SAMPLE_W-1:0]          sample_r;
  logic                         sample_valid_out;
  logic                         busy_out;
  logic                         overrun_out;

  modport master (
    output sample_valid_in, note_data_in, pan_in, mute_in, stereo_on,
    input  sample_l, sample_r, sample_valid_out, busy_out, overrun_out
  );

  modport slave (
    input  sample_valid_in, note_data_in, pan_in, mute_in, stereo_on,
    output sample_l, sample_r, sample_valid_out, busy_out, overrun_out
  );

endinterface

// File: rtl/stereo_pan_mixer_pan_gain_mac.sv
// Per-voice gain stage: turns one sample, its pan code, mute and mode into signed L/R products.
module pan_gain_mac #(
  parameter int SAMPLE_W = 16,
  parameter int PAN_W    = 4
) (
  input  logic signed [SAMPLE_W-1:0]     sample_in,
  input  logic        [PAN_W-1:0]        pan_in,
  input  logic                           mute_in,
  input  logic                           stereo_in,
  output logic signed [SAMPLE_W+PAN_W:0] prod_l_out,
  output logic signed [SAMPLE_W+PAN_W:0] prod_r_out
);

  localparam int PW = SAMPLE_W + PAN_W + 1;
  localparam logic [PAN_W-1:0] PMAX = '1;

  logic [PAN_W-1:0] gain_l;
  logic [PAN_W-1:0] gain_r;

  always_comb begin
    gain_l = stereo_in ? (PMAX - pan_in) : PMAX;
    gain_r = stereo_in ? pan_in : PMAX;
    if (mute_in) begin
      prod_l_out = '0;
      prod_r_out = '0;
    end else begin
      // Gains are unsigned; a zero MSB keeps them positive in the signed multiply.
      prod_l_out = PW'(sample_in) * PW'($signed({1'b0, gain_l}));
      prod_r_out = PW'(sample_in) * PW'($signed({1'b0, gain_r}));
    end
  end

endmodule

// File: rtl/stereo_pan_mixer.sv
// Time-multiplexed stereo mixer: one voice per clock through a single MAC pair,
// started by a frame strobe, with saturated and held L/R outputs.
module stereo_pan_mixer
  import audio_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int PAN_W    = PAN_W_DEF
) (
  input logic              clk_in,
  input logic              rst_n_in,
  stereo_pan_mixer_if.slave bus
);

  // state    | meaning
  // ST_IDLE  | waiting for a frame strobe
  // ST_ACCUM | accumulating voice idx_q into both sides
  // ST_DONE  | saturating accumulators into the output registers

  localparam int AW = SAMPLE_W + PAN_W + $clog2(NUM_CH) + 1;
  localparam int PW = SAMPLE_W + PAN_W + 1;
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);

  state_t state_q, state_d;

  logic [NUM_CH*SAMPLE_W-1:0] note_q, note_d;
  logic [NUM_CH*PAN_W-1:0]    pan_q, pan_d;
  logic [NUM_CH-1:0]          mute_q, mute_d;
  logic                       stereo_q, stereo_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic signed [AW-1:0]       acc_l_q, acc_l_d;
  logic signed [AW-1:0]       acc_r_q, acc_r_d;
  logic [SAMPLE_W-1:0]        out_l_q, out_l_d;
  logic [SAMPLE_W-1:0]        out_r_q, out_r_d;
  logic                       valid_q, valid_d;
  logic                       overrun_q, overrun_d;

  logic signed [SAMPLE_W-1:0] cur_s;
  logic [PAN_W-1:0]           cur_p;
  logic                       cur_m;
  logic signed [PW-1:0]       prod_l;
  logic signed [PW-1:0]       prod_r;
  logic signed [AW-1:0]       shift_l;
  logic signed [AW-1:0]       shift_r;

  always_comb begin
    cur_s = '0;
    cur_p = '0;
    cur_m = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx_q == IW'(k)) begin
        cur_s = note_q[k*SAMPLE_W +: SAMPLE_W];
        cur_p = pan_q[k*PAN_W +: PAN_W];
        cur_m = mute_q[k];
      end
    end
  end

  pan_gain_mac #(
    .SAMPLE_W (SAMPLE_W),
    .PAN_W    (PAN_W)
  ) u_mac (
    .sample_in  (cur_s),
    .pan_in     (cur_p),
    .mute_in    (cur_m),
    .stereo_in  (stereo_q),
    .prod_l_out (prod_l),
    .prod_r_out (prod_r)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_IDLE;
      note_q    <= '0;
      pan_q     <= '0;
      mute_q    <= '0;
      stereo_q  <= 1'b0;
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      note_q    <= note_d;
      pan_q     <= pan_d;
      mute_q    <= mute_d;
      stereo_q  <= stereo_d;
      idx_q     <= idx_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      out_l_q   <= out_l_d;
      out_r_q   <= out_r_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.sample_valid_in) state_d = ST_ACCUM;
      ST_ACCUM: if (idx_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    note_d    = note_q;
    pan_d     = pan_q;
    mute_d    = mute_q;
    stereo_d  = stereo_q;
    idx_d     = idx_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    out_l_d   = out_l_q;
    out_r_d   = out_r_q;
    valid_d   = 1'b0;
    // A strobe seen in any non-idle state, DONE included, is dropped and flagged.
    overrun_d = bus.sample_valid_in && (state_q != ST_IDLE);
    shift_l   = acc_l_q >>> PAN_W;
    shift_r   = acc_r_q >>> PAN_W;
    case (state_q)
      ST_IDLE: begin
        if (bus.sample_valid_in) begin
          note_d   = bus.note_data_in;
          pan_d    = bus.pan_in;
          mute_d   = bus.mute_in;
          stereo_d = bus.stereo_on;
          idx_d    = '0;
          acc_l_d  = '0;
          acc_r_d  = '0;
        end
      end
      ST_ACCUM: begin
        acc_l_d = acc_l_q + AW'(prod_l);
        acc_r_d = acc_r_q + AW'(prod_r);
        if (idx_q != LAST_IDX) idx_d = idx_q + IW'(1);
      end
      ST_DONE: begin
        out_l_d = SAMPLE_W'(saturate(64'(shift_l), SAMPLE_W));
        out_r_d = SAMPLE_W'(saturate(64'(shift_r), SAMPLE_W));
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.sample_l         = out_l_q;
  assign bus.sample_r         = out_r_q;
  assign bus.sample_valid_out = valid_q;
  assign bus.busy_out         = (state_q != ST_IDLE);
  assign bus.overrun_out      = overrun_q;

endmodule

// File: tb/tb_stereo_pan_mixer.sv
// Bench for stereo_pan_mixer: directed frames plus randomized strobes, compared every
// cycle against an arithmetic model of the mix and of the frame timing.
module tb_stereo_pan_mixer;
  import audio_pkg::*;

  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 16;
  localparam int PAN_W    = 4;
  localparam int NW       = NUM_CH * SAMPLE_W;
  localparam int PWD      = NUM_CH * PAN_W;
  localparam longint PMAX = (64'sd1 <<< PAN_W) - 1;
  localparam longint SMAX = (64'sd1 <<< (SAMPLE_W - 1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (SAMPLE_W - 1));

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  stereo_pan_mixer_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .PAN_W(PAN_W)) bus ();

  stereo_pan_mixer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .PAN_W(PAN_W)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc       = 0;
  int acc_edge  = 0;
  int done_edge = 0;
  int val_cnt   = 0;
  int ovr_cnt   = 0;
  longint pend_l = 0, pend_r = 0, exp_l = 0, exp_r = 0;
  logic exp_valid = 1'b0, exp_busy = 1'b0, exp_ovr = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint clamp(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  // Plain-arithmetic mix of one frame.
  function automatic void model_mix(input logic [NW-1:0] n, input logic [PWD-1:0] p,
                                    input logic [NUM_CH-1:0] m, input logic st,
                                    output longint l, output longint r);
    longint al, ar, s, g;
    al = 0;
    ar = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      s = longint'($signed(n[k*SAMPLE_W +: SAMPLE_W]));
      g = longint'(p[k*PAN_W +: PAN_W]);
      if (!m[k]) begin
        if (st) begin
          al += s * (PMAX - g);
          ar += s * g;
        end else begin
          al += s * PMAX;
          ar += s * PMAX;
        end
      end
    end
    l = clamp(al >>> PAN_W);
    r = clamp(ar >>> PAN_W);
  endfunction

  function automatic logic [NW-1:0] notes4(input int a, input int b, input int c, input int d);
    return {SAMPLE_W'(d), SAMPLE_W'(c), SAMPLE_W'(b), SAMPLE_W'(a)};
  endfunction

  function automatic logic [PWD-1:0] pans4(input int a, input int b, input int c, input int d);
    return {PAN_W'(d), PAN_W'(c), PAN_W'(b), PAN_W'(a)};
  endfunction

  // Frame timing model: a strobe accepted at edge a yields results after edge a+NUM_CH+1.
  always @(posedge clk_in) begin
    if (rst_n_in) begin
      cyc++;
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      if (bus.sample_valid_in) begin
        if (cyc > done_edge) begin
          acc_edge  = cyc;
          done_edge = cyc + NUM_CH + 1;
          model_mix(bus.note_data_in, bus.pan_in, bus.mute_in, bus.stereo_on, pend_l, pend_r);
        end else begin
          exp_ovr = 1'b1;
        end
      end
      if (cyc == done_edge) begin
        exp_l     = pend_l;
        exp_r     = pend_r;
        exp_valid = 1'b1;
      end
      exp_busy = (cyc >= acc_edge) && (cyc < done_edge);
    end
  end

  always @(negedge clk_in) begin
    chk("valid_out", longint'(bus.sample_valid_out), longint'(exp_valid));
    chk("busy_out", longint'(bus.busy_out), longint'(exp_busy));
    chk("overrun_out", longint'(bus.overrun_out), longint'(exp_ovr));
    chk("sample_l", longint'($signed(bus.sample_l)), exp_l);
    chk("sample_r", longint'($signed(bus.sample_r)), exp_r);
    if (bus.sample_valid_out) val_cnt++;
    if (bus.overrun_out) ovr_cnt++;
  end

  task automatic model_reset();
    acc_edge  = cyc;
    done_edge = cyc;
    pend_l = 0; pend_r = 0; exp_l = 0; exp_r = 0;
    exp_valid = 1'b0; exp_busy = 1'b0; exp_ovr = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic scramble();
    bus.note_data_in = {$urandom, $urandom};
    bus.pan_in       = PWD'($urandom);
    bus.mute_in      = NUM_CH'($urandom);
    bus.stereo_on    = 1'($urandom);
  endtask

  task automatic send(input logic [NW-1:0] n, input logic [PWD-1:0] p,
                      input logic [NUM_CH-1:0] m, input logic st, output int d_edge);
    bus.note_data_in    = n;
    bus.pan_in          = p;
    bus.mute_in         = m;
    bus.stereo_on       = st;
    bus.sample_valid_in = 1'b1;
    d_edge = cyc;
    tick(1);
    bus.sample_valid_in = 1'b0;
    scramble();
  endtask

  task automatic wait_valid(input string name, output longint l, output longint r, output int v_edge);
    bit seen;
    seen = 1'b0;
    l = 0; r = 0; v_edge = -1;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (bus.sample_valid_out) begin
        seen   = 1'b1;
        l      = longint'($signed(bus.sample_l));
        r      = longint'($signed(bus.sample_r));
        v_edge = cyc;
      end else begin
        tick(1);
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: actual=no valid pulse required=valid within 30 cycles", name);
    end
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1);
  end

  initial begin
    longint l, r;
    int d, ve, v0, o0;
    logic [NW-1:0]     n_hard, n_mono, n_pos, n_neg;
    logic [PWD-1:0]    p_hard, p_mono, p_zero, p_full;

    bus.sample_valid_in = 1'b0;
    bus.note_data_in    = '0;
    bus.pan_in          = '0;
    bus.mute_in         = '0;
    bus.stereo_on       = 1'b0;

    n_hard = notes4(1000, 2000, 5000, -7000);
    p_hard = pans4(0, 15, 7, 3);
    n_mono = notes4(100, 200, 300, -50);
    p_mono = pans4(5, 9, 1, 12);
    n_pos  = notes4(32767, 32767, 32767, 32767);
    n_neg  = notes4(-32768, -32768, -32768, -32768);
    p_zero = pans4(PAN_LEFT, PAN_LEFT, PAN_LEFT, PAN_LEFT);
    p_full = pans4(15, 15, 15, 15);

    repeat (3) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    tick(2);

    // Pin the model itself to hand-computed values.
    model_mix(n_hard, p_hard, 4'b1100, 1'b1, l, r);
    chk("model_hardpan_l", l, 937);
    chk("model_hardpan_r", r, 1875);
    model_mix(n_mono, p_mono, 4'b0000, 1'b0, l, r);
    chk("model_mono_l", l, 515);
    chk("model_mono_r", r, 515);
    model_mix(notes4(1600, 0, 0, 0), pans4(PAN_CENTRE, 0, 0, 0), 4'b0000, 1'b1, l, r);
    chk("model_centre_l", l, 700);
    chk("model_centre_r", r, 800);

    send(n_hard, p_hard, 4'b1100, 1'b1, d);
    wait_valid("hardpan", l, r, ve);
    chk("hardpan_l", l, 937);
    chk("hardpan_r", r, 1875);
    chk("hardpan_latency", longint'(ve - d), 6);

    send(n_mono, p_mono, 4'b0000, 1'b0, d);
    wait_valid("mono", l, r, ve);
    chk("mono_l", l, 515);
    chk("mono_r", r, 515);

    send(n_pos, p_zero, 4'b0000, 1'b1, d);
    wait_valid("sat_pos", l, r, ve);
    chk("sat_pos_l", l, 32767);
    chk("sat_pos_r", r, 0);

    send(n_neg, p_full, 4'b0000, 1'b1, d);
    wait_valid("sat_neg", l, r, ve);
    chk("sat_neg_l", l, 0);
    chk("sat_neg_r", r, -32768);

    // Reset in the middle of ACCUM, then a fresh frame.
    v0 = val_cnt;
    send(n_pos, p_zero, 4'b0000, 1'b1, d);
    tick(2);
    rst_n_in = 1'b0;
    model_reset();
    tick(3);
    rst_n_in = 1'b1;
    tick(1);
    chk("reset_no_valid", longint'(val_cnt - v0), 0);
    send(n_hard, p_hard, 4'b1100, 1'b1, d);
    wait_valid("after_reset", l, r, ve);
    chk("after_reset_l", l, 937);
    chk("after_reset_r", r, 1875);

    // Second strobe two cycles after the first.
    v0 = val_cnt; o0 = ovr_cnt;
    send(n_hard, p_hard, 4'b1100, 1'b1, d);
    tick(1);
    send(n_mono, p_mono, 4'b0000, 1'b0, d);
    wait_valid("overrun", l, r, ve);
    tick(4);
    chk("overrun_l", l, 937);
    chk("overrun_r", r, 1875);
    chk("overrun_pulses", longint'(ovr_cnt - o0), 1);
    chk("overrun_valids", longint'(val_cnt - v0), 1);

    // Strobe landing in DONE is dropped; the very next cycle is accepted.
    v0 = val_cnt; o0 = ovr_cnt;
    send(n_hard, p_hard, 4'b1100, 1'b1, d);
    tick(NUM_CH);
    send(n_pos, p_zero, 4'b0000, 1'b1, d);
    send(n_mono, p_mono, 4'b0000, 1'b0, d);
    wait_valid("done_edge", l, r, ve);
    tick(4);
    chk("done_edge_l", l, 515);
    chk("done_edge_r", r, 515);
    chk("done_edge_overruns", longint'(ovr_cnt - o0), 1);
    chk("done_edge_valids", longint'(val_cnt - v0), 2);

    // Back-to-back frames at NUM_CH+3 spacing.
    v0 = val_cnt; o0 = ovr_cnt;
    for (int i = 0; i < 8; i++) begin
      send({$urandom, $urandom}, PWD'($urandom), NUM_CH'($urandom), 1'($urandom), d);
      tick(NUM_CH + 2);
    end
    tick(8);
    chk("b2b_overruns", longint'(ovr_cnt - o0), 0);
    chk("b2b_valids", longint'(val_cnt - v0), 8);

    // Random frames with random gaps, some of which collide with a running mix.
    for (int i = 0; i < 60; i++) begin
      send({$urandom, $urandom}, PWD'($urandom), NUM_CH'($urandom & $urandom),
           1'($urandom), d);
      tick($urandom_range(0, 8));
    end
    tick(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
